// File: rtl/sdft_scheduler_pkg.sv
// sdft_pkg: FSM encoding and default geometry shared by the SDFT scheduler files.
package sdft_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT, SCAN, FLUSH} state_t;
    localparam int FREQ_BINS  = 320;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/sdft_scheduler_mag_approx.sv
// mag_approx: |re|+|im| magnitude estimate, scaled down by SHIFT and saturated to MAG_W bits.
module mag_approx #(
    parameter int DATA_W = sdft_pkg::DEF_DATA_W,
    parameter int MAG_W  = 8,
    parameter int SHIFT  = 4
) (
    input  logic signed [DATA_W-1:0] re,
    input  logic signed [DATA_W-1:0] im,
    output logic [MAG_W-1:0]         mag
);
    logic [DATA_W:0] abs_re, abs_im, sum, shifted;
    always_comb begin
        // one extra bit so abs of the most negative value does not wrap
        abs_re  = re[DATA_W-1] ? -{re[DATA_W-1], re} : {1'b0, re};
        abs_im  = im[DATA_W-1] ? -{im[DATA_W-1], im} : {1'b0, im};
        sum     = abs_re + abs_im;
        shifted = sum >> SHIFT;
        mag     = |shifted[DATA_W:MAG_W] ? '1 : shifted[MAG_W-1:0];
    end
endmodule

// File: rtl/sdft_scheduler.sv
// sdft_scheduler: kicks one SDFT update per ADC sample and, every DECIMATE samples,
// scans all bins through mag_approx into the frequency BRAM.
module sdft_scheduler #(
    parameter int FREQ_BINS = sdft_pkg::FREQ_BINS,
    parameter int ADDR_W    = sdft_pkg::DEF_ADDR_W,
    parameter int DATA_W    = sdft_pkg::DEF_DATA_W,
    parameter int MAG_W     = 8,
    parameter int SHIFT     = 4,
    parameter int DECIMATE  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adc_ready,
    output logic                     sdft_start,
    input  logic                     sdft_ready,
    output logic [ADDR_W-1:0]        bin_addr,
    input  logic signed [DATA_W-1:0] bin_real,
    input  logic signed [DATA_W-1:0] bin_imag,
    output logic                     bram_we,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [MAG_W-1:0]         bram_data,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     overrun
);
    import sdft_pkg::*;

    state_t            state, state_nx;
    logic [7:0]        dec_cnt;
    logic [ADDR_W-1:0] addr_cnt, pipe_addr;
    logic              pipe_v, wait_armed, flush_cnt, last_bin, dec_last, sdft_done;
    logic [MAG_W-1:0]  mag;

    mag_approx #(.DATA_W(DATA_W), .MAG_W(MAG_W), .SHIFT(SHIFT)) u_mag (
        .re(bin_real), .im(bin_imag), .mag(mag)
    );

    assign last_bin   = addr_cnt == ADDR_W'(FREQ_BINS - 1);
    assign dec_last   = dec_cnt == 8'(DECIMATE - 1);
    // the SDFT needs one cycle to drop sdft_ready, so the first WAIT cycle is ignored
    assign sdft_done  = state == WAIT && wait_armed && sdft_ready;
    assign bin_addr   = addr_cnt;
    assign sdft_start = state == START;
    assign busy       = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = adc_ready ? START : IDLE;
            START:   state_nx = WAIT;
            WAIT:    state_nx = sdft_done ? (dec_last ? SCAN : IDLE) : WAIT;
            SCAN:    state_nx = last_bin ? FLUSH : SCAN;
            FLUSH:   state_nx = flush_cnt ? IDLE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dec_cnt    <= '0;
            addr_cnt   <= '0;
            pipe_addr  <= '0;
            pipe_v     <= 1'b0;
            wait_armed <= 1'b0;
            flush_cnt  <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_data  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            wait_armed <= state == WAIT;
            if (sdft_done)
                dec_cnt <= dec_last ? 8'd0 : dec_cnt + 8'd1;
            // counter rests at 0 outside SCAN, so every scan starts at bin 0
            addr_cnt   <= (state == SCAN && !last_bin) ? addr_cnt + 1'b1 : '0;
            flush_cnt  <= state == FLUSH && !flush_cnt;
            pipe_v     <= state == SCAN;
            pipe_addr  <= addr_cnt;
            bram_we    <= pipe_v;
            if (pipe_v) begin
                bram_addr <= pipe_addr;
                bram_data <= mag;
            end
            frame_done <= state == FLUSH && flush_cnt;
            overrun    <= overrun | (adc_ready && state != IDLE);
        end
    end
endmodule

// File: tb/tb_sdft_scheduler.sv
// tb_sdft_scheduler: randomized bin data against an arithmetic magnitude model, two DUTs (DECIMATE 1 and 4).
module tb_sdft_scheduler;
    localparam int NB = 320;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic a_adc = 1'b0, a_start, a_rdy = 1'b1, a_we, a_done, a_busy, a_ovr;
    logic b_adc = 1'b0, b_start, b_rdy = 1'b1, b_we, b_done, b_busy, b_ovr;
    logic [8:0] a_bin, a_baddr, b_bin, b_baddr;
    logic [7:0] a_bdata, b_bdata;
    logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

    sdft_scheduler #(.DECIMATE(1)) dut_a (
        .clk(clk), .reset(reset), .adc_ready(a_adc), .sdft_start(a_start), .sdft_ready(a_rdy),
        .bin_addr(a_bin), .bin_real(a_re), .bin_imag(a_im), .bram_we(a_we), .bram_addr(a_baddr),
        .bram_data(a_bdata), .frame_done(a_done), .busy(a_busy), .overrun(a_ovr)
    );
    sdft_scheduler #(.DECIMATE(4)) dut_b (
        .clk(clk), .reset(reset), .adc_ready(b_adc), .sdft_start(b_start), .sdft_ready(b_rdy),
        .bin_addr(b_bin), .bin_real(b_re), .bin_imag(b_im), .bram_we(b_we), .bram_addr(b_baddr),
        .bram_data(b_bdata), .frame_done(b_done), .busy(b_busy), .overrun(b_ovr)
    );

    // bin memory with one cycle read latency, shared contents
    logic signed [15:0] re_mem [NB];
    logic signed [15:0] im_mem [NB];
    always @(posedge clk) begin
        a_re <= int'(a_bin) < NB ? re_mem[a_bin] : 16'sd0;
        a_im <= int'(a_bin) < NB ? im_mem[a_bin] : 16'sd0;
        b_re <= int'(b_bin) < NB ? re_mem[b_bin] : 16'sd0;
        b_im <= int'(b_bin) < NB ? im_mem[b_bin] : 16'sd0;
    end

    // SDFT model: ready drops after start and returns 5 cycles after the start pulse
    int a_lat = 0, b_lat = 0;
    always @(posedge clk) begin
        if (a_start) begin a_lat <= 4; a_rdy <= 1'b0; end
        else if (a_lat != 0) begin a_lat <= a_lat - 1; a_rdy <= a_lat == 1; end
        if (b_start) begin b_lat <= 4; b_rdy <= 1'b0; end
        else if (b_lat != 0) begin b_lat <= b_lat - 1; b_rdy <= b_lat == 1; end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wa_addr[$], wa_data[$], wa_cyc[$], wb_addr[$], wb_cyc[$];
    int a_starts = 0, a_dones = 0, a_done_cyc = 0, b_starts = 0, b_dones = 0, bad_bin = 0;
    always @(negedge clk) begin
        if (a_we) begin wa_addr.push_back(int'(a_baddr)); wa_data.push_back(int'(a_bdata)); wa_cyc.push_back(cyc); end
        if (b_we) begin wb_addr.push_back(int'(b_baddr)); wb_cyc.push_back(cyc); end
        if (a_start) a_starts++;
        if (b_start) b_starts++;
        if (a_done) begin a_dones++; a_done_cyc = cyc; end
        if (b_done) b_dones++;
        if (int'(a_bin) >= NB || int'(b_bin) >= NB || (!a_busy && a_bin != 0) || (!b_busy && b_bin != 0)) bad_bin++;
    end

    int n_cmp = 0, n_err = 0;

    function automatic int exp_mag(input int re, input int im);
        int s;
        s = ((re < 0 ? -re : re) + (im < 0 ? -im : im)) >> 4;
        return s > 255 ? 255 : s;
    endfunction

    task automatic fill_mem();
        for (int k = 0; k < NB; k++) begin
            re_mem[k] = k % 3 == 0 ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
            im_mem[k] = k % 3 == 1 ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
        end
    endtask

    task automatic pulse_a();
        @(negedge clk); a_adc = 1'b1;
        @(negedge clk); a_adc = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk); b_adc = 1'b1;
        @(negedge clk); b_adc = 1'b0;
    endtask

    task automatic run_frame_a(output bit ok);
        int d0, n;
        d0 = a_dones; n = 0;
        pulse_a();
        while (a_dones == d0 && n < 2000) begin @(negedge clk); n++; end
        @(negedge clk);
        ok = a_dones != d0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_start, a_we, a_done, a_busy, a_ovr, a_bin, a_baddr, a_bdata} !== 31'd0) begin
            n_err++; $display("FAIL reset_a: outputs=%h need 0", {a_start, a_we, a_done, a_busy, a_ovr, a_bin, a_baddr, a_bdata});
        end
        n_cmp++;
        if ({b_start, b_we, b_done, b_busy, b_ovr, b_bin, b_baddr, b_bdata} !== 31'd0) begin
            n_err++; $display("FAIL reset_b: outputs=%h need 0", {b_start, b_we, b_done, b_busy, b_ovr, b_bin, b_baddr, b_bdata});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({a_busy, a_start, a_we} !== 3'b000) begin
            n_err++; $display("FAIL idle_after_reset: busy/start/we=%b need 000", {a_busy, a_start, a_we});
        end
    endtask

    task automatic test_single_frame();
        int w0, s0, d0, nw;
        bit ok;
        fill_mem();
        w0 = wa_addr.size(); s0 = a_starts; d0 = a_dones;
        run_frame_a(ok);
        nw = wa_addr.size() - w0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_frame_timeout: frame_done not seen, need 1 pulse"); end
        n_cmp++;
        if (nw !== NB) begin n_err++; $display("FAIL single_frame_writes: got %0d need %0d", nw, NB); end
        for (int k = 0; k < NB && k < nw; k++) begin
            n_cmp++;
            if (wa_addr[w0+k] !== k || wa_data[w0+k] !== exp_mag(re_mem[k], im_mem[k]) || wa_cyc[w0+k] !== wa_cyc[w0] + k) begin
                n_err++;
                $display("FAIL single_frame_w%0d: addr=%0d data=%0d dcyc=%0d need addr=%0d data=%0d dcyc=%0d",
                         k, wa_addr[w0+k], wa_data[w0+k], wa_cyc[w0+k] - wa_cyc[w0], k, exp_mag(re_mem[k], im_mem[k]), k);
            end
        end
        n_cmp++;
        if (a_dones - d0 !== 1 || a_starts - s0 !== 1) begin
            n_err++; $display("FAIL single_frame_pulses: done=%0d start=%0d need 1 1", a_dones - d0, a_starts - s0);
        end
        n_cmp++;
        if (nw > 0 && a_done_cyc !== wa_cyc[w0+nw-1] + 1) begin
            n_err++; $display("FAIL frame_done_timing: at +%0d after last write, need +1", a_done_cyc - wa_cyc[w0+nw-1]);
        end
        n_cmp++;
        if ({a_busy, a_ovr, a_bin} !== 11'd0) begin
            n_err++; $display("FAIL single_frame_end: busy/ovr/bin=%h need 0", {a_busy, a_ovr, a_bin});
        end
    endtask

    task automatic test_saturation();
        int w0, nw;
        bit ok;
        fill_mem();
        re_mem[0] = -16'sd32768; im_mem[0] = -16'sd32768;
        re_mem[1] = 16'sd100;    im_mem[1] = -16'sd60;
        re_mem[2] = 16'sd32767;  im_mem[2] = 16'sd32767;
        re_mem[3] = 16'sd0;      im_mem[3] = -16'sd15;
        re_mem[NB-1] = -16'sd4000; im_mem[NB-1] = 16'sd80;
        w0 = wa_addr.size();
        run_frame_a(ok);
        nw = wa_addr.size() - w0;
        n_cmp++;
        if (!ok || nw !== NB) begin n_err++; $display("FAIL sat_frame: done=%0d writes=%0d need 1 %0d", ok, nw, NB); end
        if (nw == NB) begin
            n_cmp++;
            if (wa_data[w0] !== 255) begin n_err++; $display("FAIL sat_most_negative: got %0d need 255", wa_data[w0]); end
            n_cmp++;
            if (wa_data[w0+1] !== 10) begin n_err++; $display("FAIL mag_100_m60: got %0d need 10", wa_data[w0+1]); end
            n_cmp++;
            if (wa_data[w0+2] !== 255) begin n_err++; $display("FAIL sat_most_positive: got %0d need 255", wa_data[w0+2]); end
            n_cmp++;
            if (wa_data[w0+3] !== 0) begin n_err++; $display("FAIL mag_small: got %0d need 0", wa_data[w0+3]); end
            n_cmp++;
            if (wa_data[w0+NB-1] !== 255 || wa_addr[w0+NB-1] !== NB - 1) begin
                n_err++; $display("FAIL last_bin: addr=%0d data=%0d need %0d 255", wa_addr[w0+NB-1], wa_data[w0+NB-1], NB - 1);
            end
            for (int k = 4; k < NB - 1; k++) begin
                n_cmp++;
                if (wa_data[w0+k] !== exp_mag(re_mem[k], im_mem[k])) begin
                    n_err++; $display("FAIL sat_frame_w%0d: data=%0d need %0d", k, wa_data[w0+k], exp_mag(re_mem[k], im_mem[k]));
                end
            end
        end
    endtask

    task automatic test_decimate();
        int s0, w0, d0, nw, n;
        fill_mem();
        s0 = b_starts; w0 = wb_addr.size(); d0 = b_dones;
        for (int i = 1; i <= 4; i++) begin
            pulse_b();
            repeat (2000) @(negedge clk);
            nw = wb_addr.size() - w0;
            n_cmp++;
            if (b_starts - s0 !== i) begin n_err++; $display("FAIL dec_starts_%0d: got %0d need %0d", i, b_starts - s0, i); end
            n_cmp++;
            if (nw !== (i / 4) * NB || b_dones - d0 !== i / 4) begin
                n_err++; $display("FAIL dec_scan_%0d: writes=%0d dones=%0d need %0d %0d", i, nw, b_dones - d0, (i / 4) * NB, i / 4);
            end
        end
        nw = wb_addr.size() - w0;
        n = 0;
        for (int k = 0; k < nw && k < NB; k++)
            if (wb_addr[w0+k] != k || wb_cyc[w0+k] != wb_cyc[w0] + k) n++;
        n_cmp++;
        if (n !== 0) begin n_err++; $display("FAIL dec_addr_seq: %0d bad writes need 0", n); end
        n_cmp++;
        if (b_ovr !== 1'b0 || b_busy !== 1'b0) begin n_err++; $display("FAIL dec_end: ovr=%b busy=%b need 0 0", b_ovr, b_busy); end
    endtask

    task automatic test_flush_edge();
        int s0, n;
        fill_mem();
        s0 = a_starts;
        n_cmp++;
        if (a_ovr !== 1'b0) begin n_err++; $display("FAIL flush_pre_ovr: got %b need 0", a_ovr); end
        pulse_a();
        n = 0;
        while (!(a_we && a_baddr == 9'(NB - 1)) && n < 1000) begin @(negedge clk); n++; end
        n_cmp++;
        if (n >= 1000) begin n_err++; $display("FAIL flush_wait: final write not seen in %0d cycles", n); end
        a_adc = 1'b1;
        @(negedge clk);
        a_adc = 1'b0;
        n_cmp++;
        if ({a_done, a_ovr, a_busy} !== 3'b110) begin
            n_err++; $display("FAIL flush_edge: done/ovr/busy=%b need 110", {a_done, a_ovr, a_busy});
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (a_starts - s0 !== 1 || a_ovr !== 1'b1) begin
            n_err++; $display("FAIL flush_drop: starts=%0d ovr=%b need 1 1", a_starts - s0, a_ovr);
        end
    endtask

    task automatic test_overrun_scan();
        int s0, w0, nw, n;
        bit ok;
        fill_mem();
        s0 = a_starts; w0 = wa_addr.size();
        pulse_a();
        n = 0;
        while (!(a_busy && a_bin == 9'd100) && n < 500) begin @(negedge clk); n++; end
        n_cmp++;
        if (n >= 500) begin n_err++; $display("FAIL ovr_wait: bin 100 not reached in %0d cycles", n); end
        a_adc = 1'b1;
        @(negedge clk);
        a_adc = 1'b0;
        n = 0;
        while (!a_done && n < 1000) begin @(negedge clk); n++; end
        ok = a_done;
        repeat (30) @(negedge clk);
        nw = wa_addr.size() - w0;
        n_cmp++;
        if (!ok || nw !== NB) begin n_err++; $display("FAIL ovr_scan_complete: done=%0d writes=%0d need 1 %0d", ok, nw, NB); end
        for (int k = 0; k < nw && k < NB; k++) begin
            n_cmp++;
            if (wa_addr[w0+k] !== k || wa_data[w0+k] !== exp_mag(re_mem[k], im_mem[k])) begin
                n_err++; $display("FAIL ovr_scan_w%0d: addr=%0d data=%0d need %0d %0d", k, wa_addr[w0+k], wa_data[w0+k], k, exp_mag(re_mem[k], im_mem[k]));
            end
        end
        n_cmp++;
        if (a_ovr !== 1'b1 || a_starts - s0 !== 1) begin
            n_err++; $display("FAIL ovr_sticky: ovr=%b starts=%0d need 1 1", a_ovr, a_starts - s0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int w0, wb0, s0, nw, n;
        bit ok;
        s0 = b_starts; wb0 = wb_addr.size();
        for (int i = 0; i < 2; i++) begin pulse_b(); repeat (50) @(negedge clk); end
        n_cmp++;
        if (b_starts - s0 !== 2 || wb_addr.size() !== wb0) begin
            n_err++; $display("FAIL pre_reset_b: starts=%0d writes=%0d need 2 0", b_starts - s0, wb_addr.size() - wb0);
        end
        fill_mem();
        pulse_a();
        n = 0;
        while (!(a_busy && a_bin == 9'd150) && n < 500) begin @(negedge clk); n++; end
        n_cmp++;
        if (n >= 500) begin n_err++; $display("FAIL rst_wait: bin 150 not reached in %0d cycles", n); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({a_start, a_we, a_done, a_busy, a_ovr, a_bin, a_baddr, a_bdata} !== 31'd0) begin
            n_err++; $display("FAIL async_reset_a: outputs=%h need 0", {a_start, a_we, a_done, a_busy, a_ovr, a_bin, a_baddr, a_bdata});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        w0 = wa_addr.size();
        repeat (50) @(negedge clk);
        n_cmp++;
        if (wa_addr.size() !== w0) begin n_err++; $display("FAIL post_reset_writes: got %0d need 0", wa_addr.size() - w0); end
        run_frame_a(ok);
        nw = wa_addr.size() - w0;
        n_cmp++;
        if (!ok || nw !== NB) begin n_err++; $display("FAIL post_reset_frame: done=%0d writes=%0d need 1 %0d", ok, nw, NB); end
        for (int k = 0; k < nw && k < NB; k++) begin
            n_cmp++;
            if (wa_addr[w0+k] !== k || wa_data[w0+k] !== exp_mag(re_mem[k], im_mem[k])) begin
                n_err++; $display("FAIL post_reset_w%0d: addr=%0d data=%0d need %0d %0d", k, wa_addr[w0+k], wa_data[w0+k], k, exp_mag(re_mem[k], im_mem[k]));
            end
        end
        // B's decimation count must have restarted from zero
        wb0 = wb_addr.size();
        for (int i = 0; i < 3; i++) begin pulse_b(); repeat (50) @(negedge clk); end
        n_cmp++;
        if (wb_addr.size() !== wb0) begin n_err++; $display("FAIL dec_after_reset: early writes=%0d need 0", wb_addr.size() - wb0); end
        pulse_b();
        repeat (400) @(negedge clk);
        nw = wb_addr.size() - wb0;
        n_cmp++;
        if (nw !== NB || (nw > 0 && (wb_addr[wb0] !== 0 || wb_addr[wb0+nw-1] !== NB - 1))) begin
            n_err++; $display("FAIL dec_after_reset_scan: writes=%0d need %0d from bin 0 to %0d", nw, NB, NB - 1);
        end
    endtask

    task automatic test_back_to_back();
        int s0, w0, nw, bad;
        bit ok1, ok2;
        s0 = a_starts; w0 = wa_addr.size();
        fill_mem();
        run_frame_a(ok1);
        repeat ($urandom_range(0, 30)) @(negedge clk);
        run_frame_a(ok2);
        nw = wa_addr.size() - w0;
        bad = 0;
        for (int k = 0; k < nw; k++)
            if (wa_addr[w0+k] != k % NB || wa_data[w0+k] != exp_mag(re_mem[k % NB], im_mem[k % NB])) bad++;
        n_cmp++;
        if (!ok1 || !ok2 || nw !== 2 * NB || bad !== 0) begin
            n_err++; $display("FAIL back_to_back: done=%0d%0d writes=%0d bad=%0d need 11 %0d 0", ok1, ok2, nw, bad, 2 * NB);
        end
        n_cmp++;
        if (a_starts - s0 !== 2 || a_ovr !== 1'b0) begin
            n_err++; $display("FAIL back_to_back_ctl: starts=%0d ovr=%b need 2 0", a_starts - s0, a_ovr);
        end
        n_cmp++;
        if (bad_bin !== 0) begin n_err++; $display("FAIL bin_addr_range: %0d bad cycles need 0", bad_bin); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_saturation();
        test_decimate();
        test_flush_edge();
        test_overrun_scan();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdft_scheduler.md
SDFT_SCHEDULER -- requirements
Module: sdft_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- FREQ_BINS, 320, number of SDFT bins scanned per frame.
- ADDR_W, 9, bin/BRAM address width; must satisfy 2^ADDR_W >= FREQ_BINS.
- DATA_W, 16, signed width of each bin's real and imaginary parts.
- MAG_W, 8, width of the magnitude written to BRAM.
- SHIFT, 4, right shift applied to the magnitude before saturation.
- DECIMATE, 4, number of samples per frame scan; legal range 1..255.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock for all logic.
- reset, in, 1, asynchronous active-high reset.
- adc_ready, in, 1, one-cycle pulse marking a new ADC sample.
- sdft_start, out, 1, one-cycle pulse that starts an SDFT update.
- sdft_ready, in, 1, level; high when the SDFT is idle and its update is complete.
- bin_addr, out, ADDR_W, bin read address.
- bin_real, in, DATA_W, signed; valid 1 cycle after bin_addr.
- bin_imag, in, DATA_W, signed; valid 1 cycle after bin_addr.
- bram_we, out, 1, frequency BRAM write enable.
- bram_addr, out, ADDR_W, frequency BRAM write address.
- bram_data, out, MAG_W, magnitude data written to BRAM.
- frame_done, out, 1, one-cycle pulse after the last BRAM write of a frame.
- busy, out, 1, high in every state except IDLE.
- overrun, out, 1, sticky flag; set when a sample is dropped.

Function
REQ-003 FSM states: IDLE, START, WAIT, SCAN, FLUSH.
REQ-004 IDLE: on adc_ready, go to START.
REQ-005 START: assert sdft_start for exactly 1 cycle, then go to WAIT.
REQ-006 WAIT: ignore sdft_ready in the first WAIT cycle, because the SDFT needs 1 cycle to drop sdft_ready.
REQ-007 WAIT: when sdft_ready is high, increment the decimation counter (dec_cnt).
- If dec_cnt was DECIMATE-1: clear dec_cnt and go to SCAN.
- Otherwise: go to IDLE.
REQ-008 SCAN: bin_addr runs 0..FREQ_BINS-1, one address per cycle; after address FREQ_BINS-1, go to FLUSH.
REQ-009 Write pipeline: for bin_addr=k in cycle t, bram_we=1, bram_addr=k and bram_data=mag(k) in cycle t+2. Total write latency is 2 cycles.
REQ-010 FLUSH: lasts 2 cycles to drain the pipeline.
- frame_done pulses in the cycle after the final write (bram_addr=FREQ_BINS-1).
- The FSM then goes to IDLE.
REQ-011 Magnitude computation:
- Compute |re|+|im| at DATA_W+1 bits; abs(-2^(DATA_W-1)) = 2^(DATA_W-1) with no wrap.
- Shift the sum right by SHIFT.
- Saturate the result to 2^MAG_W-1.
REQ-012 Outside valid write cycles, bram_we=0 and bin_addr holds 0.
REQ-013 An adc_ready pulse in any state other than IDLE sets overrun and drops that sample: no sdft_start and no dec_cnt change. Only reset clears overrun.
REQ-014 If adc_ready coincides with the cycle in which the FSM returns to IDLE, the sample is dropped and overrun is set.
REQ-015 With DECIMATE=1, every sample produces a SCAN.
REQ-016 bin_addr never exceeds FREQ_BINS-1, and the address counter never wraps into a second pass.

Reset
REQ-017 Reset, asynchronous and active-high, forces:
- state=IDLE, dec_cnt=0;
- sdft_start=0, bram_we=0, bram_addr=0, bram_data=0, bin_addr=0;
- frame_done=0, busy=0, overrun=0.
REQ-018 Reset asserted mid-SCAN aborts the frame immediately. After release, no BRAM writes occur until the next complete SCAN.

Structure
REQ-019 Package sdft_pkg holds:
- the FSM state enum;
- FREQ_BINS;
- the ADDR_W default;
- the DATA_W default.
REQ-020 Sub-module mag_approx: purely combinational abs-sum, shift and saturate; registered by the parent.
REQ-021 No other sub-modules; a single FSM and one address counter.

Verification
REQ-022 Scenario: DECIMATE=1; one adc_ready; sdft_ready returns 5 cycles after sdft_start. Required response:
- exactly 320 writes on consecutive cycles, addresses 0..319;
- one frame_done pulse.
REQ-023 Scenario: DECIMATE=4; 4 samples spaced 2000 cycles apart. Required response:
- sdft_start pulses 4 times;
- the SCAN occurs only after the 4th sample.
REQ-024 Scenario: bin model returns re=-32768, im=-32768 (DATA_W=16, SHIFT=4, MAG_W=8). Required response: bram_data=255 (saturated). With re=100, im=-60: bram_data=10.
REQ-025 Scenario: adc_ready pulsed during SCAN at bin 100. Required response:
- overrun=1 and stays 1;
- the scan completes all 320 writes;
- no additional sdft_start.
REQ-026 Scenario: reset asserted at bin 150 for 3 cycles. Required response:
- all outputs are 0 asynchronously;
- the next sample plus DECIMATE behaviour starts cleanly from bin 0.
REQ-027 Scenario: adc_ready in the same cycle as the FLUSH-to-IDLE transition. Required response: overrun=1 and no sdft_start.
